// File: rtl/paralelo_serial_tx_pkg.sv
// rtl/paralelo_serial_tx_pkg.sv - shared characters, widths and state encoding for the lane serializer
//   Used by paralelo_serial_tx and its sub-blocks. The receive-side
//   Serial_Paralelo stage decodes the same COM/IDLE characters.
package paralelo_serial_tx_pkg;

  localparam int BYTE_W = 8;

  // Comma used for training/resync, and filler when no data is offered.
  localparam logic [BYTE_W-1:0] COM_CHAR  = 8'hBC;
  localparam logic [BYTE_W-1:0] IDLE_CHAR = 8'h7C;

  typedef enum logic {
    ST_SYNC   = 1'b0,
    ST_ACTIVE = 1'b1
  } tx_state_e;

endpackage

// File: rtl/paralelo_serial_tx_if.sv
// rtl/paralelo_serial_tx_if.sv - byte-side and lane-side signals of the lane serializer
//   data_in/valid_in/enable : upstream -> serializer
//   byte_req                : serializer -> upstream, consume strobe
//   data_out/tx_active      : serializer -> lane / status
interface paralelo_serial_tx_if;
  import paralelo_serial_tx_pkg::*;

  logic [BYTE_W-1:0] data_in;
  logic              valid_in;
  logic              enable;
  logic              byte_req;
  logic              data_out;
  logic              tx_active;

  // Upstream byte source and lane observer.
  modport master (
    output data_in, valid_in, enable,
    input  byte_req, data_out, tx_active
  );

  // The serializer itself.
  modport slave (
    input  data_in, valid_in, enable,
    output byte_req, data_out, tx_active
  );

endinterface

// File: rtl/paralelo_serial_tx_piso_shift8.sv
// rtl/paralelo_serial_tx_piso_shift8.sv - 8-bit load/shift register with bit counter, MSB first
//   clk_32f    : bit clock
//   reset_L    : asynchronous active-low reset
//   load_byte  : byte captured on a load edge
//   load_edge  : high during the cycle whose rising edge loads load_byte
//   serial_out : current serial bit (shift_reg[7])
module piso_shift8
  import paralelo_serial_tx_pkg::*;
(
  input  logic              clk_32f,
  input  logic              reset_L,
  input  logic [BYTE_W-1:0] load_byte,
  output logic              load_edge,
  output logic              serial_out
);

  logic [BYTE_W-1:0] shift_reg_q, shift_reg_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;

  // bit_cnt resets to 7 so the very first edge after release is a load.
  assign load_edge  = (bit_cnt_q == 3'd7);
  assign serial_out = shift_reg_q[BYTE_W-1];

  always_comb begin
    shift_reg_d = {shift_reg_q[BYTE_W-2:0], 1'b0};
    bit_cnt_d   = bit_cnt_q + 3'd1;
    if (load_edge) begin
      shift_reg_d = load_byte;
      bit_cnt_d   = 3'd0;
    end
  end

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      shift_reg_q <= '0;
      bit_cnt_q   <= 3'd7;
    end else begin
      shift_reg_q <= shift_reg_d;
      bit_cnt_q   <= bit_cnt_d;
    end
  end

endmodule

// File: rtl/paralelo_serial_tx.sv
// rtl/paralelo_serial_tx.sv - per-lane transmit serializer: comma training, then data/IDLE bytes
//   clk_32f       : bit clock
//   reset_L       : asynchronous active-low reset
//   bus (slave)   : data_in/valid_in/enable in; byte_req/data_out/tx_active out
//   tx_byte_count : count of valid data bytes sent (only with PS_BYTE_CNT_EN)
//   Optional feature macro: PS_BYTE_CNT_EN
module paralelo_serial_tx
  import paralelo_serial_tx_pkg::*;
#(
  parameter int COM_COUNT = 4,
  parameter int CNT_W     = 3
) (
  input  logic                  clk_32f,
  input  logic                  reset_L,
  paralelo_serial_tx_if.slave   bus
`ifdef PS_BYTE_CNT_EN
  ,
  output logic [15:0]           tx_byte_count
`endif
);

  localparam logic [CNT_W-1:0] COM_LAST = CNT_W'(COM_COUNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  tx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  com_cnt_q, com_cnt_d;
  logic [BYTE_W-1:0] next_byte;
  logic              load_edge;
  logic              serial_bit;

  piso_shift8 u_piso (
    .clk_32f    (clk_32f),
    .reset_L    (reset_L),
    .load_byte  (next_byte),
    .load_edge  (load_edge),
    .serial_out (serial_bit)
  );

  assign bus.data_out  = serial_bit;
  assign bus.tx_active = (state_q == ST_ACTIVE);
  assign bus.byte_req  = (state_q == ST_ACTIVE) && load_edge && bus.enable;

  always_comb begin
    state_d   = state_q;
    com_cnt_d = com_cnt_q;
    next_byte = COM_CHAR;
    if (load_edge) begin
      case (state_q)
        ST_SYNC: begin
          if (bus.enable) begin
            // >= rather than == so a resync (which restarts at 1) still
            // completes when COM_COUNT is 1.
            if (com_cnt_q >= COM_LAST) begin
              state_d   = ST_ACTIVE;
              com_cnt_d = '0;
            end else begin
              com_cnt_d = com_cnt_q + CNT_ONE;
            end
          end else begin
            com_cnt_d = '0;
          end
        end
        ST_ACTIVE: begin
          if (bus.enable) begin
            next_byte = bus.valid_in ? bus.data_in : IDLE_CHAR;
          end else begin
            // The COM loaded now is the first of the new training run.
            state_d   = ST_SYNC;
            com_cnt_d = CNT_ONE;
          end
        end
        default: begin
          state_d = ST_SYNC;
        end
      endcase
    end
  end

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      state_q   <= ST_SYNC;
      com_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      com_cnt_q <= com_cnt_d;
    end
  end

`ifdef PS_BYTE_CNT_EN
  logic [15:0] byte_cnt_q, byte_cnt_d;

  assign tx_byte_count = byte_cnt_q;

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    if (bus.byte_req && bus.valid_in) begin
      byte_cnt_d = byte_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      byte_cnt_q <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
    end
  end
`endif

endmodule

// File: doc/paralelo_serial_tx.md
Name: paralelo_serial_tx

Overview:
Per-lane transmit serializer for the PHY link. It takes bytes at the byte rate and drives one serial lane at clk_32f, MSB first. Its output feeds directly into the lane input (data_in0/data_in1) of the receive-side phy_rx Serial_Paralelo stage. It first transmits a comma training sequence so the receiver raises its active flag. After training it sends data bytes, or an IDLE character whenever valid_in is low.

Parameters:
COM_COUNT, 4, number of consecutive COM bytes sent after reset or resync before data is accepted (legal range 1..7)
CNT_W, 3, width of the COM counter; must hold COM_COUNT-1

Ports:
clk_32f  input  1  bit clock; all state changes on the rising edge
reset_L  input  1  reset, asynchronous assert, active-low
data_in  input  8  byte to transmit; sampled only on a load edge while byte_req=1
valid_in  input  1  data_in qualifier; sampled together with data_in
enable  input  1  lane enable; sampled only at byte boundaries
byte_req  output  1  combinational; high for the one clk_32f cycle whose rising edge consumes data_in/valid_in
data_out  output  1  serial bit; equals shift_reg[7]
tx_active  output  1  high while the state is ACTIVE

Behaviour:
- Clock and reset: one clock, clk_32f. reset_L is asynchronous and active-low.
- Reset values: shift_reg=8'h00 (so data_out=0), bit_cnt=7, com_cnt=0, state=SYNC. Therefore tx_active=0 and byte_req=0.
- Reset mid-byte: the current byte is abandoned immediately. No partial byte completes after release.
- Bit counter:
  - Each edge: if bit_cnt==7, this is a load edge: shift_reg <= next byte and bit_cnt <= 0.
  - Otherwise: shift_reg <= {shift_reg[6:0],1'b0} and bit_cnt <= bit_cnt+1.
  - Each byte occupies exactly 8 cycles.
  - The first load happens on the first edge after reset release.
- Latency: a byte loaded on edge E appears on data_out for the 8 cycles following E, bit 7 first.
- State SYNC:
  - Each load edge loads COM (8'hBC).
  - If enable=1: com_cnt increments. When the load with com_cnt==COM_COUNT-1 occurs, go to ACTIVE and clear com_cnt.
  - If enable=0: com_cnt is held at 0 and COM continues to be sent.
- State ACTIVE, on each load edge:
  - enable=1 and valid_in=1: load data_in.
  - enable=1 and valid_in=0: load IDLE (8'h7C).
  - enable=0: load COM, set com_cnt=1, go to SYNC (resync). This counts as the first COM of the new training.
- byte_req = (state==ACTIVE) && (bit_cnt==7) && enable.
  - It is never asserted in SYNC.
  - The upstream must hold data_in/valid_in stable across that cycle.
- Changes on enable, valid_in or data_in between load edges have no effect.
- Simultaneous events:
  - The SYNC→ACTIVE transition takes effect after the final COM load. The first byte_req follows 8 cycles later.
  - enable falling on the same edge as a data byte_req: COM wins and data_in is dropped. The upstream sees byte_req fall combinationally and must not count that byte as consumed.
- No backpressure beyond byte_req. The block never stalls.

Optional Feature:
Macro PS_BYTE_CNT_EN.
- Defined: adds output tx_byte_count [15:0], reset to 0. It increments on each load edge that loads data_in with valid_in=1, wraps 16'hFFFF→16'h0000, and is unaffected by COM/IDLE/resync.
- Undefined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- Shared package: COM_CHAR=8'hBC, IDLE_CHAR=8'h7C, BYTE_W=8, state encoding (SYNC=1'b0, ACTIVE=1'b1).
- phy_rx's Serial_Paralelo uses the same character constants.
- One natural sub-module: piso_shift8. It holds the 8-bit load/shift register and the bit counter, and outputs load_edge and serial bit. The parent holds the FSM, byte selection and the optional counter.

Test Plan:
- Reset release, enable=1: the first 32 data_out bits are 10111100 ×4. tx_active rises with the 4th COM load. byte_req first pulses 8 cycles after the 4th COM load.
- ACTIVE with valid_in=0: data_out streams 01111100 repeatedly. byte_req pulses every 8 cycles.
- ACTIVE with data_in=8'hA5 and valid_in=1 on the byte_req cycle: the next 8 bits are 1,0,1,0,0,1,0,1. Then IDLE if valid drops.
- enable=0 at a byte boundary in ACTIVE: COM is sent, tx_active=0. Re-enable → 3 more COMs (4 total), then back to ACTIVE. data_in offered on the dropped edge never appears.
- reset_L pulsed low at bit 3 of a 8'hA5 byte: data_out is 0 immediately. After release, 4 COMs are sent before any data.
- PS_BYTE_CNT_EN defined:
  - Send 3 valid bytes plus 2 IDLEs: tx_byte_count=3.
  - Preload/force to 16'hFFFF, then one valid byte: count=0.
